// File: rtl/ariane_pkg.sv
// Shared frontend types plus the fetch queue sizing constants and width helpers.
package ariane_pkg;

  localparam int unsigned VLEN = 64;

  typedef enum logic [2:0] {
    NoCF,
    Branch,
    Jump,
    JumpR,
    Return
  } cf_t;

  typedef struct packed {
    cf_t             cf;
    logic [VLEN-1:0] predict_address;
  } branch_predict_sbe_t;

  typedef struct packed {
    logic [VLEN-1:0]     address;
    logic [31:0]         instruction;
    branch_predict_sbe_t branch_predict;
    logic                bp_taken;
    logic                page_fault;
    logic [2:0]          id;
  } frontend_fetch_t;

  localparam int unsigned FETCH_FIFO_DEPTH = 8;
  localparam int unsigned FETCH_ENTRY_W    = $bits(frontend_fetch_t);
  localparam int unsigned FETCH_FIFO_PTR_W = $clog2(FETCH_FIFO_DEPTH);
  localparam int unsigned FETCH_FIFO_CNT_W = FETCH_FIFO_PTR_W + 1;

  function automatic bit is_valid_fifo_depth(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_sync_core.sv
// Generic typed synchronous FIFO: count-based full/empty, unreset storage with
// an asynchronous read of the head slot.
module fifo_sync_core
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = logic
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  T                       data_i,
  output T                       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  if (!is_valid_fifo_depth(DEPTH)) begin : g_bad_depth
    $error("fifo_sync_core: DEPTH must be a power of two and at least 2");
  end

  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  T mem_q [DEPTH];

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  // Full refuses a push even when a pop happens in the same cycle.
  assign push_ok = push_i & ~full_o & ~clear_i;
  assign pop_ok  = pop_i & ~empty_o & ~clear_i;

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PTR_W'(1);
      if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
      cnt_d = cnt_q + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= FULL_CNT)
    else $error("fifo_sync_core: count exceeds DEPTH");

endmodule

// File: rtl/fetch_fifo.sv
// Instruction fetch queue between frontend and realigner: flush priority,
// reset-gated handshake outputs and an occupancy port around fifo_sync_core.
module fetch_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [FETCH_ENTRY_W-1:0] fetch_entry_i,
  input  logic                     fetch_entry_valid_i,
  output logic                     fetch_entry_ready_o,
  output logic [FETCH_ENTRY_W-1:0] fetch_entry_o,
  output logic                     fetch_entry_valid_o,
  input  logic                     fetch_ack_i,
  output logic [$clog2(DEPTH):0]   fifo_usage_o
);

  if (!is_valid_fifo_depth(DEPTH)) begin : g_bad_depth
    $error("fetch_fifo: DEPTH must be a power of two and at least 2");
  end

  frontend_fetch_t        wr_entry, rd_entry;
  logic                   full, empty;
  logic                   push, pop;
  logic [$clog2(DEPTH):0] count;

  assign wr_entry = frontend_fetch_t'(fetch_entry_i);

  // Ready and valid come from registered occupancy only, masked while in reset.
  assign fetch_entry_ready_o = rst_ni & ~full;
  assign fetch_entry_valid_o = rst_ni & ~empty;
  assign fifo_usage_o        = rst_ni ? count : '0;
  assign fetch_entry_o       = rd_entry;

  assign push = fetch_entry_valid_i & fetch_entry_ready_o & ~flush_i;
  assign pop  = fetch_ack_i & fetch_entry_valid_o & ~flush_i;

  fifo_sync_core #(
    .DEPTH (DEPTH),
    .T     (frontend_fetch_t)
  ) i_core (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (wr_entry),
    .data_o  (rd_entry),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> fetch_entry_ready_o)
    else $error("fetch_fifo: push accepted while not ready");

  a_head_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (fetch_entry_valid_o && !fetch_ack_i && !flush_i) |=> $stable(fetch_entry_o))
    else $error("fetch_fifo: head changed while stalled");

endmodule

// File: tb/tb_fetch_fifo.sv
// Scoreboard bench for fetch_fifo: a reference queue tracks pushes, and every
// cycle the DUT handshake, occupancy and head entry are compared against it.
module tb_fetch_fifo;
  import ariane_pkg::*;

  localparam int DEPTH = FETCH_FIFO_DEPTH;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush = 1'b0;
  frontend_fetch_t        entry_in = '0;
  logic                   valid_in = 1'b0;
  logic                   ready_out;
  logic [FETCH_ENTRY_W-1:0] entry_out;
  logic                   valid_out;
  logic                   ack = 1'b0;
  logic [$clog2(DEPTH):0] usage;

  int vectors = 0;
  int miscompares = 0;
  frontend_fetch_t sb[$];

  always #5 clk = ~clk;

  fetch_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .flush_i             (flush),
    .fetch_entry_i       (entry_in),
    .fetch_entry_valid_i (valid_in),
    .fetch_entry_ready_o (ready_out),
    .fetch_entry_o       (entry_out),
    .fetch_entry_valid_o (valid_out),
    .fetch_ack_i         (ack),
    .fifo_usage_o        (usage)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic frontend_fetch_t mk(input logic [63:0] a, input logic [2:0] id, input logic pf);
    frontend_fetch_t e;
    e.address                        = a;
    e.instruction                    = a[31:0] ^ 32'hA5A5_0013;
    e.branch_predict.cf              = a[2] ? Branch : NoCF;
    e.branch_predict.predict_address = a + 64'h40;
    e.bp_taken                       = a[3];
    e.page_fault                     = pf;
    e.id                             = id;
    return e;
  endfunction

  // One clock: drive at negedge, check registered-state outputs, advance model.
  task automatic cyc(input logic rst, input logic v, input frontend_fetch_t e,
                     input logic a, input logic fl);
    int n;
    @(negedge clk);
    rst_n = rst; valid_in = v; entry_in = e; ack = a; flush = fl;
    #1;
    n = sb.size();
    check_eq("ready", ready_out, rst && (n != DEPTH));
    check_eq("valid", valid_out, rst && (n != 0));
    check_eq("usage", usage, rst ? n : 0);
    if (rst && n != 0) check_eq("head", entry_out, sb[0]);
    $display("t=%0t rst_n=%0b v=%0b addr=%0h ack=%0b flush=%0b usage=%0d model=%0d",
             $time, rst, v, e.address, a, fl, usage, n);
    if (!rst || fl) begin
      sb.delete();
    end else begin
      if (a && n == 0) $display("note: protocol error, ack while empty (ignored)");
      if (a && n != 0) void'(sb.pop_front());
      if (v && n != DEPTH) sb.push_back(e);
    end
  endtask

  frontend_fetch_t held;
  logic [63:0] addr;

  initial begin
    // Reset
    cyc(0, 0, '0, 0, 0);
    cyc(0, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    // Three pushes, no ack
    for (int i = 0; i < 3; i++) cyc(1, 1, mk(64'h1000 + 64'(4 * i), 3'(i), 0), 0, 0);
    cyc(1, 0, '0, 0, 0);
    // Fill to DEPTH, then a refused 9th push
    for (int i = 3; i < DEPTH; i++) cyc(1, 1, mk(64'h1000 + 64'(4 * i), 3'(i), 0), 0, 0);
    cyc(1, 1, mk(64'h2000, 3'd7, 0), 0, 0);
    cyc(1, 1, mk(64'h2004, 3'd7, 0), 1, 0);
    cyc(1, 0, '0, 0, 0);
    // Drain to 4, then 20 cycles of simultaneous push and pop
    for (int i = 0; i < 3; i++) cyc(1, 0, '0, 1, 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, mk(64'h3000 + 64'(4 * i), 3'(i), 0), 1, 0);
    cyc(1, 0, '0, 0, 0);
    // Flush at usage 5 with a same-cycle push and ack
    cyc(1, 1, mk(64'h4000, 3'd1, 0), 0, 0);
    cyc(1, 1, mk(64'hDEAD_0000, 3'd2, 0), 1, 1);
    cyc(1, 0, '0, 0, 0);
    // Reset mid-stream at usage 6
    for (int i = 0; i < 6; i++) cyc(1, 1, mk(64'h5000 + 64'(4 * i), 3'(i), 0), 0, 0);
    cyc(0, 1, mk(64'hBAD0, 3'd5, 0), 1, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    // Ack while empty, then a faulting entry held for 10 stall cycles
    cyc(1, 0, '0, 1, 0);
    cyc(1, 1, mk(64'h6000, 3'd3, 1), 0, 0);
    held = sb[0];
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, '0, 0, 0);
      check_eq("hold", entry_out, held);
    end
    // Drain with random stimulus
    for (int i = 0; i < 40; i++) begin
      addr = 64'h7000 + 64'(4 * i);
      cyc(1, 1'($urandom_range(0, 1)), mk(addr, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) cyc(1, 0, '0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
